// File: rtl/pass_lock_fsm.sv
// pass_lock_fsm: password-gated access controller.
//
// A session starts when req rises. The first confirm edge presents the
// password. On a match, the next confirm edge presents a direction word.
// That word enables the right channel (bit 0 = 0) or the left channel
// (bit 0 = 1) and is latched on dout. Dropping req aborts the session.
// While in WAIT_PASS or GRANTED, an inactivity timer sends the FSM to
// DENIED if no confirm edge arrives in time.
//
// Build option: define LOCKOUT_EN to add the wrong-attempt counter and the
// LOCKED state. Without it, fail_cnt and locked are tied to 0 and every
// password mismatch goes to DENIED.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req        session request (level); low aborts the session
//   confirm    entry strobe; only its rising edge acts
//   pass_data  password or direction word
//   en_left    left channel enable
//   en_right   right channel enable
//   dout       latched direction word
//   state      current state encoding
//   locked     high while in LOCKED
//   fail_cnt   consecutive wrong-password count
module pass_lock_fsm #(
  parameter int unsigned       PASS_W         = 4,
  parameter logic [PASS_W-1:0] PASSWORD       = 4'b0101,
  parameter int unsigned       MAX_TRIES      = 3,
  parameter int unsigned       LOCK_CYCLES    = 16,
  parameter int unsigned       TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  input  logic                           confirm,
  input  logic [PASS_W-1:0]              pass_data,
  output logic                           en_left,
  output logic                           en_right,
  output logic [PASS_W-1:0]              dout,
  output logic [2:0]                     state,
  output logic                           locked,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);

  localparam int unsigned FailW    = $clog2(MAX_TRIES + 1);
  // One timer serves both the inactivity timeout and the lockout count.
  localparam int unsigned TimerMax = (TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  typedef enum logic [2:0] {
    StIdle     = 3'b000,
    StWaitPass = 3'b001,
    StGranted  = 3'b101,
    StDone     = 3'b110,
    StDenied   = 3'b111,
    StLocked   = 3'b100
  } state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                confirm_q;
  logic                en_left_q, en_left_d;
  logic                en_right_q, en_right_d;
  logic [PASS_W-1:0]   dout_q, dout_d;
  logic                conf_edge;
  logic                timeout_hit;

`ifdef LOCKOUT_EN
  logic [FailW-1:0]    fail_q, fail_d;
  logic                locked_q, locked_d;
`endif

  assign conf_edge   = confirm & ~confirm_q;
  assign timeout_hit = (timer_q == TimerW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    en_left_d  = en_left_q;
    en_right_d = en_right_q;
    dout_d     = dout_q;
`ifdef LOCKOUT_EN
    fail_d     = fail_q;
`endif

    // A dropped req overrides a confirm edge and a timeout. LOCKED is the
    // one state that keeps running without req.
    if (!req && (state_q != StLocked)) begin
      state_d    = StIdle;
      en_left_d  = 1'b0;
      en_right_d = 1'b0;
      dout_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StWaitPass;
        end
        StWaitPass: begin
          if (conf_edge) begin
            if (pass_data == PASSWORD) begin
              state_d = StGranted;
`ifdef LOCKOUT_EN
              fail_d  = '0;
`endif
            end else begin
`ifdef LOCKOUT_EN
              fail_d  = fail_q + FailW'(1);
              state_d = (fail_d == FailW'(MAX_TRIES)) ? StLocked : StDenied;
`else
              state_d = StDenied;
`endif
            end
          end else if (timeout_hit) begin
            state_d = StDenied;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        StGranted: begin
          if (conf_edge) begin
            if (pass_data[0]) begin
              en_left_d  = 1'b1;
            end else begin
              en_right_d = 1'b1;
            end
            dout_d  = pass_data;
            state_d = StDone;
          end else if (timeout_hit) begin
            state_d = StDenied;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        StDone: begin
          // Hold the granted channel until req drops.
        end
        StDenied: begin
          en_left_d  = 1'b0;
          en_right_d = 1'b0;
          dout_d     = '0;
        end
        StLocked: begin
`ifdef LOCKOUT_EN
          if (timer_q == TimerW'(LOCK_CYCLES - 1)) begin
            state_d = StIdle;
            fail_d  = '0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
`else
          state_d = StIdle;
`endif
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Every state entry restarts the timer.
    if (state_d != state_q) begin
      timer_d = '0;
    end
  end

`ifdef LOCKOUT_EN
  always_comb begin
    locked_d = (state_d == StLocked);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      confirm_q  <= 1'b0;
      en_left_q  <= 1'b0;
      en_right_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      confirm_q  <= confirm;
      en_left_q  <= en_left_d;
      en_right_q <= en_right_d;
      dout_q     <= dout_d;
    end
  end

`ifdef LOCKOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      fail_q   <= fail_d;
      locked_q <= locked_d;
    end
  end

  assign fail_cnt = fail_q;
  assign locked   = locked_q;
`else
  assign fail_cnt = '0;
  assign locked   = 1'b0;
`endif

  assign state    = state_q;
  assign en_left  = en_left_q;
  assign en_right = en_right_q;
  assign dout     = dout_q;

endmodule

// File: tb/tb_pass_lock_fsm.sv
// Directed testbench for pass_lock_fsm with its default parameters.
// When LOCKOUT_EN is defined, the lockout sequence is checked. Otherwise
// the bench checks that the attempt counter and the locked output stay at 0.
module tb_pass_lock_fsm;

  logic       clk;
  logic       rst;
  logic       req;
  logic       confirm;
  logic [3:0] pass_data;
  logic       en_left;
  logic       en_right;
  logic [3:0] dout;
  logic [2:0] state;
  logic       locked;
  logic [1:0] fail_cnt;

  int unsigned n_vec;
  int unsigned n_miss;
  logic [1:0]  exp_fail;

  pass_lock_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .confirm   (confirm),
    .pass_data (pass_data),
    .en_left   (en_left),
    .en_right  (en_right),
    .dout      (dout),
    .state     (state),
    .locked    (locked),
    .fail_cnt  (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    req     = 1'b1;
    confirm = 1'b0;
    tick();
    check_eq("start_state", 32'(state), 32'h1);
  endtask

  // One cycle with confirm low, then a rising edge carrying d.
  task automatic enter(input logic [3:0] d);
    pass_data = d;
    confirm   = 1'b0;
    tick();
    confirm   = 1'b1;
    tick();
  endtask

  task automatic abort_session();
    req     = 1'b0;
    confirm = 1'b0;
    tick();
    check_eq("abort_state", 32'(state), 32'h0);
    check_eq("abort_en", {30'd0, en_left, en_right}, 32'h0);
    check_eq("abort_dout", 32'(dout), 32'h0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst       = 1'b0;
    req       = 1'b0;
    confirm   = 1'b0;
    pass_data = 4'h0;
    #12;
    check_eq("rst_state", 32'(state), 32'h0);
    check_eq("rst_en", {30'd0, en_left, en_right}, 32'h0);
    check_eq("rst_dout", 32'(dout), 32'h0);
    check_eq("rst_locked", 32'(locked), 32'h0);
    check_eq("rst_fail", 32'(fail_cnt), 32'h0);
    rst = 1'b1;
    tick();
    check_eq("idle_state", 32'(state), 32'h0);

    // Correct password, then a right-channel word.
    start_session();
    enter(4'b0101);
    check_eq("grant_state", 32'(state), 32'h5);
    check_eq("grant_no_en", {30'd0, en_left, en_right}, 32'h0);
    enter(4'b0110);
    check_eq("right_state", 32'(state), 32'h6);
    check_eq("right_en_r", 32'(en_right), 32'h1);
    check_eq("right_en_l", 32'(en_left), 32'h0);
    check_eq("right_dout", 32'(dout), 32'h6);
    tick();
    check_eq("done_hold", 32'(state), 32'h6);
    abort_session();

    // Left channel.
    start_session();
    enter(4'b0101);
    enter(4'b0011);
    check_eq("left_state", 32'(state), 32'h6);
    check_eq("left_en", {30'd0, en_left, en_right}, 32'h2);
    check_eq("left_dout", 32'(dout), 32'h3);
    abort_session();

    // Confirm held high across the grant is not a second edge.
    start_session();
    enter(4'b0101);
    pass_data = 4'b0110;
    tick();
    check_eq("held_state1", 32'(state), 32'h5);
    tick();
    check_eq("held_state2", 32'(state), 32'h5);
    check_eq("held_no_en", {30'd0, en_left, en_right}, 32'h0);
    enter(4'b0110);
    check_eq("held_done", 32'(state), 32'h6);
    check_eq("held_en_r", 32'(en_right), 32'h1);
    abort_session();

    // req=0 wins over a simultaneous correct-password edge.
    start_session();
    pass_data = 4'b0101;
    req       = 1'b0;
    confirm   = 1'b1;
    tick();
    check_eq("prio_abort", 32'(state), 32'h0);
    confirm = 1'b0;

    // Wrong passwords.
    start_session();
    enter(4'b1111);
    check_eq("wrong1_state", 32'(state), 32'h7);
`ifdef LOCKOUT_EN
    check_eq("wrong1_fail", 32'(fail_cnt), 32'h1);
`else
    check_eq("wrong1_fail", 32'(fail_cnt), 32'h0);
`endif
    tick();
    check_eq("denied_hold", 32'(state), 32'h7);
    check_eq("denied_en", {30'd0, en_left, en_right}, 32'h0);
    abort_session();
    start_session();
    enter(4'b1111);
    check_eq("wrong2_state", 32'(state), 32'h7);
`ifdef LOCKOUT_EN
    check_eq("wrong2_fail", 32'(fail_cnt), 32'h2);
`endif
    abort_session();
    start_session();
    enter(4'b1111);
`ifdef LOCKOUT_EN
    check_eq("lock_state", 32'(state), 32'h4);
    check_eq("lock_locked", 32'(locked), 32'h1);
    check_eq("lock_fail", 32'(fail_cnt), 32'h3);
    // LOCKED ignores req and confirm for 16 cycles in total.
    for (int i = 0; i < 15; i++) begin
      req     = i[0];
      confirm = i[1];
      tick();
    end
    check_eq("lock_last", 32'(state), 32'h4);
    req     = 1'b1;
    confirm = 1'b0;
    tick();
    check_eq("unlock_state", 32'(state), 32'h0);
    check_eq("unlock_locked", 32'(locked), 32'h0);
    check_eq("unlock_fail", 32'(fail_cnt), 32'h0);
    tick();
    check_eq("unlock_wait", 32'(state), 32'h1);
    abort_session();
    // A correct password after one wrong one clears the count.
    start_session();
    enter(4'b1111);
    check_eq("reset_fail1", 32'(fail_cnt), 32'h1);
    abort_session();
    start_session();
    enter(4'b0101);
    check_eq("reset_fail0", 32'(fail_cnt), 32'h0);
    abort_session();
    exp_fail = 2'd1;
`else
    check_eq("nolock_state", 32'(state), 32'h7);
    check_eq("nolock_locked", 32'(locked), 32'h0);
    check_eq("nolock_fail", 32'(fail_cnt), 32'h0);
    exp_fail = 2'd0;
`endif
    abort_session();

    // Timeout: leave one wrong attempt on the counter first.
    start_session();
    enter(4'b1010);
    abort_session();
    start_session();
    for (int i = 0; i < 63; i++) begin
      tick();
    end
    check_eq("to_before", 32'(state), 32'h1);
    tick();
    check_eq("to_state", 32'(state), 32'h7);
    check_eq("to_fail", 32'(fail_cnt), 32'(exp_fail));
    tick();
    check_eq("to_hold", 32'(state), 32'h7);
    abort_session();

    // Asynchronous reset while in DONE.
    start_session();
    enter(4'b0101);
    enter(4'b0100);
    check_eq("pre_rst_en", 32'(en_right), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_state", 32'(state), 32'h0);
    check_eq("arst_en", {30'd0, en_left, en_right}, 32'h0);
    check_eq("arst_dout", 32'(dout), 32'h0);
    #1;
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
